serial_word_assembler: RTL

//   Parametrised serial-to-parallel word assembler; successor to the 16-bit 1-bit demux.
//   - Collects LANE_W-bit beats into a WORD_W-bit word using an internal beat counter.
//   - Presents each completed word in a registered output stage with a valid/ready handshake.
//   - Sits between a serial input front-end and the word-wide logic cores.

---
 rtl/serial_word_assembler.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler.
// Gathers LANE_W-bit beats into a WORD_W-bit word and hands each finished word
// to a one-deep registered output stage guarded by a valid/ready handshake.
//
//   state | meaning
//   EMPTY | no completed word held, out_valid low
//   FULL  | out holds a completed word awaiting out_ready
//
// Only the final beat of a word can be back-pressured; earlier beats go into
// the assembly register even while the output stage is stalled.
module serial_word_assembler #(
    parameter int WORD_W    = 16,
    parameter int LANE_W    = 1,
    parameter bit MSB_FIRST = 1'b0,
    localparam int BEATS    = WORD_W / LANE_W,
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [LANE_W-1:0] in,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_t;

    stage_t            state;
    stage_t            state_nxt;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] merged;
    logic [CNT_W-1:0]  lane_sel;
    logic              last_beat;
    logic              accept;
    logic              final_accept;

    assign last_beat    = (count == CNT_W'(BEATS - 1));
    assign out_valid    = (state == FULL);
    assign in_ready     = !(last_beat && out_valid && !out_ready);
    // clr wins over a same-cycle beat, so a beat presented with clr is dropped
    assign accept       = in_valid && in_ready && !clr;
    assign final_accept = accept && last_beat;
    assign lane_sel     = MSB_FIRST ? (CNT_W'(BEATS - 1) - count) : count;

    // Assembly register with the current beat dropped into its lane slot
    always_comb begin
        merged = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (lane_sel == CNT_W'(b)) begin
                merged[b*LANE_W +: LANE_W] = in;
            end
        end
    end

    // Beat counter and partial-word register; both restart after a full word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            asm_q <= '0;
        end else if (clr) begin
            count <= '0;
            asm_q <= '0;
        end else if (accept) begin
            if (last_beat) begin
                count <= '0;
                asm_q <= '0;
            end else begin
                count <= count + CNT_W'(1);
                asm_q <= merged;
            end
        end
    end

    // Output word register; loads only when a word completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (final_accept) begin
            out <= merged;
        end
    end

    // Output stage state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output stage next state; a final beat with out_ready reloads in place
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (final_accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (final_accept) begin
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

endmodule
